// File: rtl/sbox_sched.sv
// Time-multiplexed DES substitution: one shared S-box lookup per cycle, 8 groups per word.
// Optional macro SBOX_SCHED_BACK2BACK_EN lets a new word enter directly from DONE.
module sbox_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [47:0] r_hold;
    logic [31:0] r_result;
    logic        w_in_ready;
    logic        w_accept;
    logic [5:0]  w_group;

    // Group idx+1 in DES numbering; group 1 sits in the most significant six bits.
    function automatic logic [5:0] group_of(input logic [47:0] hold, input logic [2:0] idx);
        logic [5:0] g;
        case (idx)
            3'd0:    g = hold[47:42];
            3'd1:    g = hold[41:36];
            3'd2:    g = hold[35:30];
            3'd3:    g = hold[29:24];
            3'd4:    g = hold[23:18];
            3'd5:    g = hold[17:12];
            3'd6:    g = hold[11:6];
            3'd7:    g = hold[5:0];
            default: g = 6'd0;
        endcase
        return g;
    endfunction

    // Replace nibble idx+1 (S1 is the most significant nibble).
    function automatic logic [31:0] put_nibble(input logic [31:0] res, input logic [2:0] idx,
                                               input logic [3:0] nib);
        logic [31:0] r;
        r = res;
        case (idx)
            3'd0:    r[31:28] = nib;
            3'd1:    r[27:24] = nib;
            3'd2:    r[23:20] = nib;
            3'd3:    r[19:16] = nib;
            3'd4:    r[15:12] = nib;
            3'd5:    r[11:8]  = nib;
            3'd6:    r[7:4]   = nib;
            3'd7:    r[3:0]   = nib;
            default: r        = res;
        endcase
        return r;
    endfunction

    assign w_group  = group_of(r_hold, r_cnt);
    assign w_accept = in_valid & w_in_ready;

    // Next-state and input-ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef SBOX_SCHED_BACK2BACK_EN
                w_in_ready = out_ready;
                if (out_ready && in_valid) begin
                    w_state_nxt = ST_RUN;
                end else if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
`else
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, group counter, captured word and assembled result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_hold   <= 48'd0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hold <= in_data;
                r_cnt  <= 3'd0;
            end else if (r_state == ST_RUN) begin
                r_result <= put_nibble(r_result, r_cnt, sbox_out);
                r_cnt    <= r_cnt + 3'd1;
            end
        end
    end

    // S-box address is driven only while running so the shared table sees zeros otherwise.
    always_comb begin
        sbox_sel = 3'd0;
        sbox_in  = 6'd0;
        if (r_state == ST_RUN) begin
            sbox_sel = r_cnt;
            sbox_in  = w_group;
        end else begin
            sbox_sel = 3'd0;
            sbox_in  = 6'd0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_result;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Directed + random bench for sbox_sched with a table-based DES S-box reference.
module tb_sbox_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int tbl [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [3:0] sb(input int s, input logic [5:0] a);
        int row;
        int col;
        row = {30'd0, a[5], a[0]};
        col = {28'd0, a[4:1]};
        return 4'(tbl[s][row*16 + col]);
    endfunction

    function automatic logic [5:0] grp(input logic [47:0] d, input int i);
        return d[47-6*i -: 6];
    endfunction

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 8; k++) r = (r << 4) | {28'd0, sb(k, grp(d, k))};
        return r;
    endfunction

    always_comb sbox_out = sb({29'd0, sbox_sel}, sbox_in);

    sbox_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sbox_sel(sbox_sel), .sbox_in(sbox_in), .sbox_out(sbox_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ovalid"}, {47'd0, out_valid}, 48'd0);
        chk({tag, "_odata"},  {16'd0, out_data},  48'd0);
        chk({tag, "_busy"},   {47'd0, busy},      48'd0);
        chk({tag, "_iready"}, {47'd0, in_ready},  48'd1);
        chk({tag, "_sel"},    {45'd0, sbox_sel},  48'd0);
        chk({tag, "_sin"},    {42'd0, sbox_in},   48'd0);
    endtask

    // One word: accept, 8 RUN cycles, DONE held for `stall` cycles while in_valid is offered.
    task automatic run_txn(input logic [47:0] d, input int stall);
        logic [31:0] exp_r;
        exp_r = model(d);
        out_ready = (stall == 0);
        for (int w = 0; w < 20 && !in_ready; w++) step();
        chk("accept_ready", {47'd0, in_ready}, 48'd1);
        in_valid = 1'b1;
        in_data  = d;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("run_sel",    {45'd0, sbox_sel},  48'(i));
            chk("run_sin",    {42'd0, sbox_in},   {42'd0, grp(d, i)});
            chk("run_busy",   {47'd0, busy},      48'd1);
            chk("run_ovalid", {47'd0, out_valid}, 48'd0);
            chk("run_iready", {47'd0, in_ready},  48'd0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom} ^ 64'd0;
            step();
        end
        in_valid = 1'b0;
        chk("done_ovalid", {47'd0, out_valid}, 48'd1);
        chk("done_odata",  {16'd0, out_data},  {16'd0, exp_r});
        chk("done_sel",    {45'd0, sbox_sel},  48'd0);
        chk("done_sin",    {42'd0, sbox_in},   48'd0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom} ^ 64'd0;
            step();
            chk("stall_ovalid", {47'd0, out_valid}, 48'd1);
            chk("stall_odata",  {16'd0, out_data},  {16'd0, exp_r});
            chk("stall_iready", {47'd0, in_ready},  48'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_ovalid", {47'd0, out_valid}, 48'd0);
        chk("post_busy",   {47'd0, busy},      48'd0);
        chk("post_iready", {47'd0, in_ready},  48'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 48'd0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // All-zero and all-one words against known DES values.
        chk("model_zero", {16'd0, model(48'h0)}, {16'd0, 32'hEFA72C4D});
        run_txn(48'h000000000000, 0);
        chk("zero_result", {16'd0, out_data}, {16'd0, 32'hEFA72C4D});
        run_txn(48'hFFFFFFFFFFFF, 0);
        chk("ones_result", {16'd0, out_data}, {16'd0, 32'hD9CE3DCB});

        // Back-pressure for 5 cycles with a competing word offered.
        run_txn({$urandom, $urandom} ^ 64'd0, 5);
        run_txn(48'h123456789ABC, 0);

        // Reset in the middle of RUN with cnt == 4.
        in_valid = 1'b1; in_data = 48'hA5A5A5A5A5A5;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_sel", {45'd0, sbox_sel}, 48'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        run_txn(48'h000000000000, 0);
        chk("after_rst_result", {16'd0, out_data}, {16'd0, 32'hEFA72C4D});

        for (int n = 0; n < 12; n++) run_txn({$urandom, $urandom} ^ 64'd0, $urandom_range(0, 3));

`ifdef SBOX_SCHED_BACK2BACK_EN
        // Output and input handshakes in the same DONE cycle.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 48'h0;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("b2b_v1",     {47'd0, out_valid}, 48'd1);
        chk("b2b_d1",     {16'd0, out_data},  {16'd0, 32'hEFA72C4D});
        chk("b2b_iready", {47'd0, in_ready},  48'd1);
        in_valid = 1'b1; in_data = 48'hFFFFFFFFFFFF;
        step();
        in_valid = 1'b0;
        chk("b2b_busy", {47'd0, busy},     48'd1);
        chk("b2b_sin",  {42'd0, sbox_in},  48'h3F);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_gap", {47'd0, out_valid}, 48'd0);
            step();
        end
        chk("b2b_v2", {47'd0, out_valid}, 48'd1);
        chk("b2b_d2", {16'd0, out_data},  {16'd0, 32'hD9CE3DCB});
        step();
        chk("b2b_end", {47'd0, out_valid}, 48'd0);
        out_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
- REQ-001 Parameters: none; group count fixed at 8, group width 6, result nibble width 4.
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, synchronous, active-high.
- REQ-004 in_valid  input  1  48-bit expanded/key-mixed word offered.
- REQ-005 in_ready  output  1  block can accept a word this cycle.
- REQ-006 in_data  input  48  [48:1], DES numbering; group k (k=1..8) = bits [54-6k:49-6k], group 1 = [48:43].
- REQ-007 sbox_sel  output  3  selects shared S-box table: 0..7 -> S1..S8.
- REQ-008 sbox_in  output  6  6-bit address to selected S-box, abcdef format.
- REQ-009 sbox_out  input  4  combinational S-box result for sbox_sel/sbox_in, same cycle.
- REQ-010 out_valid  output  1  32-bit substitution result available.
- REQ-011 out_ready  input  1  consumer accepts result.
- REQ-012 out_data  output  32  [32:1]; S(k) nibble at bits [36-4k:33-4k], S1 at [32:29].
- REQ-013 busy  output  1  high in RUN or DONE.

Function
- REQ-014 FSM states: IDLE, RUN, DONE; 3-bit group counter cnt (0..7).
- REQ-015 in_ready SHALL be 1 in IDLE only (see REQ-027 for the optional exception).
- REQ-016 IDLE: on in_valid & in_ready, capture in_data into 48-bit hold register, cnt<=0, go RUN.
- REQ-017 RUN: sbox_sel = cnt; sbox_in = group (cnt+1) of hold register; both combinational from registered state.
- REQ-018 RUN: each cycle write sbox_out into nibble (cnt+1) of result register; cnt<=cnt+1.
- REQ-019 RUN with cnt==7: write last nibble, cnt wraps to 0, go DONE.
- REQ-020 DONE: out_valid=1; out_data = result register, stable until handshake.
- REQ-021 DONE with out_ready=1: out_valid drops next cycle, go IDLE.
- REQ-022 Latency: accept at edge T -> out_valid high in the cycle following edge T+8 (8 RUN cycles); min throughput 1 word per 10 cycles.
- REQ-023 in_valid outside IDLE SHALL be ignored; in_data not sampled.
- REQ-024 out_ready while out_valid=0 SHALL be ignored.
- REQ-025 In IDLE and DONE, sbox_sel=0 and sbox_in=0.

Reset
- REQ-026 rst=1 at an edge: state<=IDLE, cnt<=0, hold and result registers<=0; next cycle out_valid=0, out_data=0, busy=0, in_ready=1, sbox_sel=0, sbox_in=0; applies mid-RUN or mid-DONE (partial result discarded, no out_valid).

Configuration
- REQ-027 Macro SBOX_SCHED_BACK2BACK_EN defined: in DONE, in_ready = out_ready; simultaneous out and in handshake goes DONE->RUN directly, cnt<=0, new word captured; throughput 1 word per 9 cycles.
- REQ-028 Macro undefined: in_ready=0 in DONE; IDLE cycle always required between words.

Verification (bench models S1..S8 combinationally on sbox_sel/sbox_in)
- REQ-029 in_data=48'h000000000000, out_ready=1 -> out_data=32'hEFA72C4D, out_valid exactly 9 cycles after accept, one cycle wide.
- REQ-030 in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB; sbox_sel sequence 0..7 observed in RUN.
- REQ-031 out_ready held 0 for 5 cycles in DONE, in_valid=1 with new data -> out_data/out_valid stable, in_ready=0 (macro off), second word accepted only after IDLE.
- REQ-032 rst asserted at RUN cnt==4 -> next cycle all outputs at reset values; following word 48'h0 yields 32'hEFA72C4D.
- REQ-033 Macro on: two back-to-back words 48'h0, 48'hFFFFFFFFFFFF, out_ready=1 -> results EFA72C4D then D9CE3DCB, out_valid pulses 9 cycles apart.
